// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and lane helpers for dmem_bank
//
// Purpose: access-size encodings, the INIT/RUN state type, and pure functions
// for alignment checking, byte-enable generation, store-data replication and
// load extraction/extension. Used by dmem_bank.
// Ports: none (package).
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // 1 when the access cannot be performed: misaligned half/word or the
  // reserved size encoding.
  function automatic logic access_error(input logic [1:0] size,
                                        input logic [1:0] off);
    logic err;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = off[0];
      SIZE_W:  err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Little-endian lane enables: lane k holds byte offset k of the word.
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data arrives right-aligned; copying it into every candidate lane
  // lets the byte enables alone pick the destination.
  function automatic logic [31:0] store_lanes(input logic [31:0] wdata,
                                              input logic [1:0]  size);
    logic [31:0] lanes;
    case (size)
      SIZE_B:  lanes = {4{wdata[7:0]}};
      SIZE_H:  lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Move the addressed byte/half down to bit 0 and extend it. Words are
  // returned untouched regardless of the unsigned flag.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// rtl/dmem_lane_ram.sv - four byte-lane synchronous RAM with registered read
//
// Purpose: 2^ADDR_W words x 4 independent 8-bit lanes. One write port with a
// per-lane enable and one read port whose output register only updates when
// ren is high, so a read result stays put until the next read.
// Ports:
//   clock  in   rising-edge clock
//   wen    in   4   per-lane write enable
//   waddr  in   ADDR_W word index for writes
//   wdata  in   32  lane k written from bits [8k+7:8k]
//   ren    in   1   capture array word at raddr into rdata
//   raddr  in   ADDR_W word index for reads
//   rdata  out  32  registered read data
module dmem_lane_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] rd;

    always_ff @(posedge clock) begin
      if (wen[k]) begin
        mem[waddr] <= wdata[8*k +: 8];
      end
      if (ren) begin
        rd <= mem[raddr];
      end
    end

    assign rdata[8*k +: 8] = rd;
  end

endmodule

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte-addressed data memory with MIPS load/store sizing
//
// Purpose: word-organised data memory for the MEM stage. Accepts one
// load/store request per cycle over a valid/ready handshake, returns exactly
// one in-order response per request, flags misaligned/illegal accesses, and
// optionally zero-fills the whole array after reset before accepting work.
// Ports:
//   clock         in   rising-edge clock
//   ctrl_reset_n  in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  request can be accepted this cycle
//   req_we        in   1 = store, 0 = load
//   req_size      in   2  00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   zero-extend byte/half loads
//   req_addr      in   ADDR_W+2 byte address
//   req_wdata     in   32 right-aligned store data
//   resp_valid    out  response present
//   resp_ready    in   consumer takes response
//   resp_rdata    out  32 extended load data; 0 for stores and errors
//   resp_err      out  request was misaligned or illegal size
//   init_done     out  fill finished, block accepting requests
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  state_t            state;
  logic [ADDR_W-1:0] fill_cnt;

  // Metadata captured at accept so the registered RAM word can be steered
  // and extended while the response is presented.
  logic              resp_load;
  logic [1:0]        resp_size;
  logic [1:0]        resp_off;
  logic              resp_uns;

  logic              accept;
  logic              req_bad;
  logic [1:0]        req_off;
  logic [ADDR_W-1:0] req_word;

  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic              ram_ren;
  logic [31:0]       ram_rdata;

  assign req_off  = req_addr[1:0];
  assign req_word = req_addr[ADDR_W+1:2];
  assign req_bad  = access_error(req_size, req_off);

  assign req_ready = (state == RUN) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign init_done = (state == RUN);

  // During INIT the write port belongs to the fill counter; in RUN it is
  // driven by accepted, well-formed stores. Faulty requests never touch
  // the array.
  always_comb begin
    ram_wen   = 4'b0000;
    ram_waddr = req_word;
    ram_wdata = store_lanes(req_wdata, req_size);
    if (state == INIT) begin
      ram_waddr = fill_cnt;
      ram_wdata = 32'h0000_0000;
      if (CLEAR_ON_RESET) begin
        ram_wen = 4'b1111;
      end
    end else if (accept && req_we && !req_bad) begin
      ram_wen = byte_en(req_size, req_off);
    end
  end

  // The read register only advances on an accepted load, which is what
  // keeps resp_rdata steady while a response is stalled.
  assign ram_ren = accept && !req_we && !req_bad;

  dmem_lane_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock (clock),
    .wen   (ram_wen),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .ren   (ram_ren),
    .raddr (req_word),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state      <= INIT;
      fill_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_load  <= 1'b0;
      resp_size  <= SIZE_B;
      resp_off   <= 2'b00;
      resp_uns   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (!CLEAR_ON_RESET || (fill_cnt == {ADDR_W{1'b1}})) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= req_bad;
            resp_load  <= !req_we && !req_bad;
            resp_size  <= req_size;
            resp_off   <= req_off;
            resp_uns   <= req_unsigned;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_load  <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Stores and errored requests report zero data.
  assign resp_rdata = (resp_valid && resp_load)
                      ? load_extend(ram_rdata, resp_size, resp_off, resp_uns)
                      : 32'h0000_0000;

endmodule
